clip_control: RTL
=================

CLIP_CONTROL -- requirements
Module: clip_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles required to accept a button change (10 ms at 100 MHz).
REQ-002 SHALL have parameter NUM_CLIPS, default 10, the number of selectable clips; legal range 2..16.
REQ-003 SHALL have port clock_i, input, 1 bit, system clock; the block uses one clock domain.
REQ-004 SHALL have port reset_i, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports btn_play_i, btn_record_i, btn_up_i and btn_down_i, each input, 1 bit, raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port sel_target_i, input, 1 bit: 0 = up/down edits the play clip, 1 = up/down edits the record clip; sampled synchronously and not debounced.
REQ-007 SHALL have port done_i, input, 1 bit, a one-cycle pulse from the audio engine meaning the current clip finished.
REQ-008 SHALL have ports play_clip_o and record_clip_o, each output, 4 bits, the selected clip indices, which feed the display driver.
REQ-009 SHALL have ports play_start_o and record_start_o, each output, 1 bit, one-cycle start strobes.
REQ-010 SHALL have port state_o, output, 2 bits: 00 = IDLE, 01 = PLAYING, 10 = RECORDING; 11 is never driven.

Function
REQ-011 SHALL pass each button through its own two-flop synchronizer before any other logic.
REQ-012 SHALL debounce each synchronized button as follows:
- One counter per button.
- The counter increments while the synchronized value differs from the debounced level.
- The counter clears on any cycle where they match.
- The debounced level toggles, and the counter clears, on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 SHALL generate a one-cycle press event on each 0->1 transition of a debounced level; releases SHALL generate no event.
REQ-014 SHALL produce any strobe or index change exactly DEBOUNCE_CYCLES+3 clock cycles after a raw button rises and then stays stable.
REQ-015 SHALL, in IDLE:
- On a play press: go to PLAYING and pulse play_start_o for one cycle.
- On a record press: go to RECORDING and pulse record_start_o for one cycle.
REQ-016 SHALL, in IDLE with play and record presses in the same cycle, enter RECORDING; play_start_o stays low.
REQ-017 SHALL, in IDLE, apply an up press as follows: the index selected by sel_target_i increments, wrapping NUM_CLIPS-1 -> 0.
REQ-018 SHALL, in IDLE, apply a down press as follows: the selected index decrements, wrapping 0 -> NUM_CLIPS-1.
REQ-019 SHALL leave the indices unchanged when up and down presses occur in the same cycle.
REQ-020 SHALL apply a start strobe in the same cycle as an up/down press; the strobe is issued and the index also updates.
REQ-021 SHALL, in PLAYING:
- Return to IDLE on a play press or on done_i.
- Ignore record, up and down presses.
REQ-022 SHALL, in RECORDING:
- Return to IDLE on a record press or on done_i.
- Ignore play, up and down presses.
REQ-023 SHALL ignore done_i in IDLE.
REQ-024 SHALL never drive play_clip_o or record_clip_o outside 0..NUM_CLIPS-1.
REQ-025 SHALL drive all outputs directly from registers.

Reset
REQ-026 SHALL, while reset_i=0, asynchronously force the following:
- state_o = 00.
- play_clip_o = 0 and record_clip_o = 0.
- play_start_o = 0 and record_start_o = 0.
- All synchronizer flops, debounced levels and counters = 0.
REQ-027 SHALL abandon any in-progress debounce or state when reset is asserted mid-operation; no strobe is produced from pre-reset history.
REQ-028 SHALL treat a button held through reset release like a fresh press: it produces one press event DEBOUNCE_CYCLES+3 cycles after release.

Verification
REQ-029 SHALL be verified with DEBOUNCE_CYCLES=4, NUM_CLIPS=10:
- btn_play_i high for 20 cycles in IDLE -> exactly one play_start_o pulse, 7 cycles after the rise; state_o=01.
REQ-030 SHALL be verified with a glitch:
- btn_record_i high for 3 cycles, then low -> no record_start_o; state_o stays 00.
REQ-031 SHALL be verified for index wrap:
- sel_target_i=0, play_clip_o=9, up press -> play_clip_o=0.
- Then a down press -> play_clip_o=9.
- record_clip_o unchanged throughout.
REQ-032 SHALL be verified for simultaneous events:
- Play and record pressed together in IDLE -> state_o=10; record_start_o pulses; play_start_o never pulses.
REQ-033 SHALL be verified for lockout and exit:
- In PLAYING, an up press -> play_clip_o unchanged.
- done_i pulse -> state_o=00 the next cycle.
REQ-034 SHALL be verified for reset mid-operation:
- reset_i low for 1 cycle while RECORDING with record_clip_o=3 -> immediately state_o=00 and record_clip_o=0; no strobes after release.

Source files
------------

// File: rtl/clip_control.sv
// Clip selection and transport control: four debounced push-buttons drive a
// small IDLE / PLAYING / RECORDING state machine and two wrapping clip indices.
module clip_control #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_CLIPS       = 10
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       btn_play_i,
  input  logic       btn_record_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       sel_target_i,
  input  logic       done_i,
  output logic [3:0] play_clip_o,
  output logic [3:0] record_clip_o,
  output logic       play_start_o,
  output logic       record_start_o,
  output logic [1:0] state_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [3:0]    IDX_LAST = 4'(NUM_CLIPS - 1);

  localparam int B_PLAY = 0;
  localparam int B_REC  = 1;
  localparam int B_UP   = 2;
  localparam int B_DOWN = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_PLAYING   = 2'b01,
    ST_RECORDING = 2'b10
  } state_t;

  function automatic logic [3:0] idx_inc(input logic [3:0] v);
    if (v >= IDX_LAST) return 4'd0;
    else               return v + 4'd1;
  endfunction

  function automatic logic [3:0] idx_dec(input logic [3:0] v);
    if (v == 4'd0 || v > IDX_LAST) return IDX_LAST;
    else                           return v - 4'd1;
  endfunction

  logic [3:0]    btn_raw_s;
  logic [3:0]    sync1_r, sync2_r;
  logic [3:0]    deb_r, deb_d_r;
  logic [CW-1:0] cnt_r [4];
  logic [3:0]    press_s;

  state_t     state_r, state_nx_s;
  logic [3:0] play_clip_r, play_clip_nx_s;
  logic [3:0] record_clip_r, record_clip_nx_s;
  logic       play_start_r, play_start_s;
  logic       record_start_r, record_start_s;

  assign btn_raw_s = {btn_down_i, btn_up_i, btn_record_i, btn_play_i};
  assign press_s   = deb_r & ~deb_d_r;

  // Two-flop synchronizers for the raw buttons.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-button stability counters; the level flips only after a full run of differing samples.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      deb_r   <= 4'b0000;
      deb_d_r <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_r[i] <= CNT_ZERO;
    end else begin
      deb_d_r <= deb_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          deb_r[i] <= ~deb_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Next-state, index edits and start strobes from the press events.
  always_comb begin
    state_nx_s       = state_r;
    play_clip_nx_s   = play_clip_r;
    record_clip_nx_s = record_clip_r;
    play_start_s     = 1'b0;
    record_start_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Record wins over play when both arrive together.
        if (press_s[B_REC]) begin
          state_nx_s     = ST_RECORDING;
          record_start_s = 1'b1;
        end else if (press_s[B_PLAY]) begin
          state_nx_s   = ST_PLAYING;
          play_start_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
        if (press_s[B_UP] && !press_s[B_DOWN]) begin
          if (sel_target_i) record_clip_nx_s = idx_inc(record_clip_r);
          else              play_clip_nx_s   = idx_inc(play_clip_r);
        end else if (press_s[B_DOWN] && !press_s[B_UP]) begin
          if (sel_target_i) record_clip_nx_s = idx_dec(record_clip_r);
          else              play_clip_nx_s   = idx_dec(play_clip_r);
        end else begin
          play_clip_nx_s   = play_clip_r;
          record_clip_nx_s = record_clip_r;
        end
      end
      ST_PLAYING: begin
        if (press_s[B_PLAY] || done_i) state_nx_s = ST_IDLE;
        else                           state_nx_s = ST_PLAYING;
      end
      ST_RECORDING: begin
        if (press_s[B_REC] || done_i) state_nx_s = ST_IDLE;
        else                          state_nx_s = ST_RECORDING;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, index and strobe registers; every output comes straight from here.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r        <= ST_IDLE;
      play_clip_r    <= 4'd0;
      record_clip_r  <= 4'd0;
      play_start_r   <= 1'b0;
      record_start_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      play_clip_r    <= play_clip_nx_s;
      record_clip_r  <= record_clip_nx_s;
      play_start_r   <= play_start_s;
      record_start_r <= record_start_s;
    end
  end

  assign state_o        = state_r;
  assign play_clip_o    = play_clip_r;
  assign record_clip_o  = record_clip_r;
  assign play_start_o   = play_start_r;
  assign record_start_o = record_start_r;

endmodule
